// File: rtl/uart_pkg.sv
// uart_pkg: frame-format constants and tx state encoding shared by the UART transmitter and receiver
package uart_pkg;
  localparam int UART_CLKS_PER_BIT = 4;
  localparam int UART_DATA_BITS = 8;
  localparam int UART_STOP_BITS = 1;
  localparam int UART_FRAME_CLKS = (1 + UART_DATA_BITS + UART_STOP_BITS) * UART_CLKS_PER_BIT;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_e;
endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: free-running bit-period down-counter; restart reloads, bit_tick marks the last clk of a bit
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic bit_tick,
  output logic pre_tick
);
  localparam int CW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] TOP = CW'(CLKS_PER_BIT - 1);
  logic [CW-1:0] cnt_q;
  always_ff @(posedge clk or negedge reset)
    if (!reset) cnt_q <= '0;
    else cnt_q <= (restart || cnt_q == '0) ? TOP : cnt_q - CW'(1);
  assign bit_tick = cnt_q == '0;
  assign pre_tick = cnt_q == CW'(1);
endmodule

// File: rtl/uart_transmitter.sv
// uart_transmitter: double-buffered (THR + TSR) 8N1 UART transmitter at 4x baud; CLKS_PER_BIT must be >= 2
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int DATA_BITS = UART_DATA_BITS,
  parameter int STOP_BITS = UART_STOP_BITS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] d_in,
  input  logic                 tx_load,
  output logic                 tx_data,
  output logic                 thr_empty,
  output logic                 tx_status,
  output logic                 tx_done,
  output logic                 tx_overrun
);
  localparam int BW = $clog2(DATA_BITS + 1);
  tx_state_e state_q;
  logic [DATA_BITS-1:0] thr_q, tsr_q;
  logic [BW-1:0] bit_cnt_q;
  logic tx_data_q, thr_empty_q, tx_status_q, tx_done_q, tx_overrun_q;
  logic bit_tick, pre_tick, last_stop, transfer;
  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk(clk),
    .reset(reset),
    .restart(state_q == IDLE),
    .bit_tick(bit_tick),
    .pre_tick(pre_tick)
  );
  assign last_stop = bit_cnt_q == BW'(STOP_BITS - 1);
  // THR empties into TSR either from idle or straight out of the final stop clk, so frames abut
  assign transfer = !thr_empty_q && (state_q == IDLE || (state_q == STOP && bit_tick && last_stop));
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= IDLE;
      thr_q <= '0;
      tsr_q <= '0;
      bit_cnt_q <= '0;
      tx_data_q <= 1'b1;
      thr_empty_q <= 1'b1;
      tx_status_q <= 1'b0;
      tx_done_q <= 1'b0;
      tx_overrun_q <= 1'b0;
    end else begin
      tx_overrun_q <= tx_load && !thr_empty_q;
      tx_done_q <= state_q == STOP && last_stop && pre_tick;
      if (tx_load && thr_empty_q) begin
        thr_q <= d_in;
        thr_empty_q <= 1'b0;
      end
      if (transfer) begin
        tsr_q <= thr_q;
        thr_empty_q <= 1'b1;
        tx_data_q <= 1'b0;
        tx_status_q <= 1'b1;
        bit_cnt_q <= '0;
        state_q <= START;
      end else begin
        case (state_q)
          IDLE: begin
            tx_data_q <= 1'b1;
            bit_cnt_q <= '0;
          end
          START: if (bit_tick) begin
            tx_data_q <= tsr_q[0];
            state_q <= DATA;
          end
          DATA: if (bit_tick) begin
            tsr_q <= tsr_q >> 1;
            if (bit_cnt_q == BW'(DATA_BITS - 1)) begin
              bit_cnt_q <= '0;
              tx_data_q <= 1'b1;
              state_q <= STOP;
            end else begin
              bit_cnt_q <= bit_cnt_q + BW'(1);
              tx_data_q <= tsr_q[1];
            end
          end
          STOP: if (bit_tick) begin
            if (last_stop) begin
              tx_status_q <= 1'b0;
              state_q <= IDLE;
            end else bit_cnt_q <= bit_cnt_q + BW'(1);
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  assign tx_data = tx_data_q;
  assign thr_empty = thr_empty_q;
  assign tx_status = tx_status_q;
  assign tx_done = tx_done_q;
  assign tx_overrun = tx_overrun_q;
endmodule
